// File: rtl/ccr_rst_seq.sv
// Multi-domain reset sequencer: debounces board reset, qualifies PLL lock, releases domains in ascending order.
// Latency: domain 0 leaves reset SYNC+DEBOUNCE+LOCK+1 edges after board reset release; each later domain STAGE_DELAY after.
// Backpressure: none; a software request outside RUN is dropped, and lock loss always wins over a software request.
module ccr_rst_seq #(
    parameter int NUM_DOMAINS_p                   = 3,
    parameter int SYSRST_DEBOUNCE_COUNTER_VALUE_p = 15,
    parameter int PLL_LOCK_COUNTER_VALUE_p        = 20,
    parameter int STAGE_DELAY_p                   = 4,
    parameter int SW_HOLD_CYCLES_p                = 8,
    parameter int SYNC_STAGES_p                   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_sysrst_n,
    input  logic                     i_pll_locked,
    input  logic                     i_sw_rst_req,
    output logic [NUM_DOMAINS_p-1:0] o_rst_n,
    output logic [1:0]               o_rst_cause,
    output logic                     o_busy
);

    localparam int REL_SPAN_C = STAGE_DELAY_p * (NUM_DOMAINS_p - 1);
    localparam int MAX_A_C    = (SYSRST_DEBOUNCE_COUNTER_VALUE_p > PLL_LOCK_COUNTER_VALUE_p) ?
                                SYSRST_DEBOUNCE_COUNTER_VALUE_p : PLL_LOCK_COUNTER_VALUE_p;
    localparam int MAX_B_C    = (REL_SPAN_C > SW_HOLD_CYCLES_p) ? REL_SPAN_C : SW_HOLD_CYCLES_p;
    localparam int CNT_MAX_C  = (MAX_A_C > MAX_B_C) ? MAX_A_C : MAX_B_C;
    localparam int CNT_W_C    = $clog2(CNT_MAX_C) + 1;

    localparam logic [CNT_W_C-1:0] DEB_LAST_C  = CNT_W_C'(SYSRST_DEBOUNCE_COUNTER_VALUE_p - 1);
    localparam logic [CNT_W_C-1:0] LOCK_LAST_C = CNT_W_C'(PLL_LOCK_COUNTER_VALUE_p - 1);
    localparam logic [CNT_W_C-1:0] HOLD_LAST_C = CNT_W_C'(SW_HOLD_CYCLES_p - 1);
    localparam logic [CNT_W_C-1:0] REL_LAST_C  = CNT_W_C'(REL_SPAN_C);
    localparam logic [CNT_W_C-1:0] CNT_ONE_C   = CNT_W_C'(1);

    localparam logic [1:0] CAUSE_SYSRST_C = 2'b01;
    localparam logic [1:0] CAUSE_LOCK_C   = 2'b10;
    localparam logic [1:0] CAUSE_SW_C     = 2'b11;

    typedef enum logic [2:0] {
        ST_DEBOUNCE  = 3'd0,
        ST_LOCK_WAIT = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_SW_HOLD   = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W_C-1:0]       cnt_q, cnt_d;
    logic [NUM_DOMAINS_p-1:0] rst_n_q, rst_n_d;
    logic [1:0]               cause_q, cause_d;
    logic [SYNC_STAGES_p-1:0] sysrst_sync_q;
    logic [SYNC_STAGES_p-1:0] lock_sync_q;
    logic                     sysrst_ok;
    logic                     lock_ok;

    // Both chains are cleared by board reset so a glitch also discards stale lock history.
    always_ff @(posedge i_clk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            sysrst_sync_q <= '0;
            lock_sync_q   <= '0;
        end else begin
            sysrst_sync_q <= {sysrst_sync_q[SYNC_STAGES_p-2:0], 1'b1};
            lock_sync_q   <= {lock_sync_q[SYNC_STAGES_p-2:0], i_pll_locked};
        end
    end

    assign sysrst_ok = sysrst_sync_q[SYNC_STAGES_p-1];
    assign lock_ok   = lock_sync_q[SYNC_STAGES_p-1];

    always_ff @(posedge i_clk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            state_q <= ST_DEBOUNCE;
            cnt_q   <= '0;
            rst_n_q <= '0;
            cause_q <= CAUSE_SYSRST_C;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_n_q <= rst_n_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_n_d = rst_n_q;
        cause_d = cause_q;
        unique case (state_q)
            ST_DEBOUNCE: begin
                if (sysrst_ok) begin
                    if (cnt_q == DEB_LAST_C) begin
                        state_d = ST_LOCK_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE_C;
                    end
                end
            end
            ST_LOCK_WAIT: begin
                if (!lock_ok) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST_C) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE_C;
                end
            end
            ST_RELEASE: begin
                if (!lock_ok) begin
                    state_d = ST_LOCK_WAIT;
                    cnt_d   = '0;
                    rst_n_d = '0;
                    cause_d = CAUSE_LOCK_C;
                end else begin
                    // Domain k leaves reset when the stage counter reaches k*STAGE_DELAY.
                    for (int k = 0; k < NUM_DOMAINS_p; k++) begin
                        if (cnt_q == CNT_W_C'(k * STAGE_DELAY_p)) begin
                            rst_n_d[k] = 1'b1;
                        end
                    end
                    if (cnt_q == REL_LAST_C) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE_C;
                    end
                end
            end
            ST_RUN: begin
                if (!lock_ok) begin
                    state_d = ST_LOCK_WAIT;
                    cnt_d   = '0;
                    rst_n_d = '0;
                    cause_d = CAUSE_LOCK_C;
                end else if (i_sw_rst_req) begin
                    state_d = ST_SW_HOLD;
                    cnt_d   = '0;
                    rst_n_d = '0;
                    cause_d = CAUSE_SW_C;
                end
            end
            ST_SW_HOLD: begin
                if (!lock_ok) begin
                    state_d = ST_LOCK_WAIT;
                    cnt_d   = '0;
                    cause_d = CAUSE_LOCK_C;
                end else if (cnt_q == HOLD_LAST_C) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE_C;
                end
            end
            default: begin
                state_d = ST_DEBOUNCE;
                cnt_d   = '0;
                rst_n_d = '0;
            end
        endcase
    end

    assign o_rst_n     = rst_n_q;
    assign o_rst_cause = cause_q;
    assign o_busy      = ~&rst_n_q;

endmodule

// File: tb/tb_ccr_rst_seq.sv
// Directed bench for ccr_rst_seq: expected output transitions are queued with their cycle and matched as they appear.
module tb_ccr_rst_seq;

    localparam int STAGE_C = 4;

    logic       tb_clk = 1'b0;
    logic       sysrst_n;
    logic       pll_locked;
    logic       sw_rst_req;
    logic [2:0] rst_n;
    logic [1:0] rst_cause;
    logic       busy;

    typedef struct {
        int         cyc;
        logic [2:0] rst;
        logic [1:0] cause;
        logic       busy;
    } exp_t;

    exp_t       sb[$];
    int         cyc    = 0;
    int         n_chk  = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    logic       mon_en = 1'b0;
    logic [5:0] prev;

    ccr_rst_seq dut (
        .i_clk        (tb_clk),
        .i_sysrst_n   (sysrst_n),
        .i_pll_locked (pll_locked),
        .i_sw_rst_req (sw_rst_req),
        .o_rst_n      (rst_n),
        .o_rst_cause  (rst_cause),
        .o_busy       (busy)
    );

    always #5 tb_clk = ~tb_clk;

    always @(posedge tb_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [2:0] r, input logic [1:0] ca, input logic b);
        exp_t e;
        e.cyc   = c;
        e.rst   = r;
        e.cause = ca;
        e.busy  = b;
        sb.push_back(e);
    endtask

    // Staggered release: domain 0 at c0, then one domain every STAGE_C cycles.
    task automatic push_release(input int c0, input logic [1:0] ca);
        push(c0,               3'b001, ca, 1'b1);
        push(c0 + STAGE_C,     3'b011, ca, 1'b1);
        push(c0 + 2 * STAGE_C, 3'b111, ca, 1'b0);
    endtask

    // Returns 1 ns after the falling edge at which the cycle counter equals c.
    task automatic at_cyc(input int c);
        @(negedge tb_clk);
        while (cyc < c) @(negedge tb_clk);
        #1;
    endtask

    initial begin : monitor
        logic [5:0] snap;
        exp_t       e;
        forever begin
            @(negedge tb_clk);
            if (mon_en) begin
                snap = {rst_n, rst_cause, busy};
                if (snap !== prev) begin
                    check("sb_has_entry", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("evt_cycle", cyc, e.cyc);
                        check("evt_rst_n", rst_n, e.rst);
                        check("evt_cause", rst_cause, e.cause);
                        check("evt_busy", busy, e.busy);
                    end
                    prev = snap;
                end
            end
        end
    end

    initial begin
        sysrst_n   = 1'b1;
        pll_locked = 1'b1;
        sw_rst_req = 1'b0;
        #1 sysrst_n = 1'b0;
        #1;
        check("por_rst_n", rst_n, 3'b000);
        check("por_cause", rst_cause, 2'b01);
        check("por_busy", busy, 1'b1);
        prev   = {rst_n, rst_cause, busy};
        mon_en = 1'b1;

        // Power-on release with lock held high: 2 + 15 + 20 + 1 edges to domain 0.
        at_cyc(3);
        sysrst_n = 1'b1;
        push_release(3 + 38, 2'b01);

        // Lock loss in RUN: visible 2 sync edges + 1 later; relock needs 20 qualified cycles.
        at_cyc(55);
        pll_locked = 1'b0;
        push(58, 3'b000, 2'b10, 1'b1);
        at_cyc(60);
        pll_locked = 1'b1;
        push_release(60 + 23, 2'b10);

        // Software request: 8-cycle hold, no lock wait; a second request during release is dropped.
        at_cyc(96);
        sw_rst_req = 1'b1;
        push(97, 3'b000, 2'b11, 1'b1);
        at_cyc(97);
        sw_rst_req = 1'b0;
        push_release(106, 2'b11);
        at_cyc(107);
        sw_rst_req = 1'b1;
        at_cyc(108);
        sw_rst_req = 1'b0;

        // Lock loss and software request seen on the same edge: lock loss wins.
        at_cyc(120);
        pll_locked = 1'b0;
        at_cyc(122);
        sw_rst_req = 1'b1;
        push(123, 3'b000, 2'b10, 1'b1);
        at_cyc(123);
        sw_rst_req = 1'b0;

        // Relock, then a one-cycle lock drop at lock count 12 restarts qualification.
        at_cyc(126);
        pll_locked = 1'b1;
        at_cyc(138);
        pll_locked = 1'b0;
        at_cyc(139);
        pll_locked = 1'b1;
        push_release(141 + 21, 2'b10);

        // Board reset in RUN is asynchronous.
        at_cyc(176);
        sysrst_n = 1'b0;
        push(177, 3'b000, 2'b01, 1'b1);
        #1;
        check("async_rst_n", rst_n, 3'b000);
        check("async_cause", rst_cause, 2'b01);
        check("async_busy", busy, 1'b1);
        at_cyc(179);
        sysrst_n = 1'b1;

        // One-cycle glitch at debounce count 10 restarts the whole sequence.
        at_cyc(191);
        sysrst_n = 1'b0;
        #1;
        check("glitch_rst_n", rst_n, 3'b000);
        check("glitch_cause", rst_cause, 2'b01);
        at_cyc(192);
        sysrst_n = 1'b1;
        push_release(192 + 38, 2'b01);

        at_cyc(250);
        check("sb_drained", sb.size(), 0);
        check("final_rst_n", rst_n, 3'b111);
        check("final_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
